down_counter_timer: RTL and testbench

Programmable 4-bit-class down-counting timer, the count-down counterpart of the team's free-running up counter. It loads a start value and decrements to zero at a prescaled rate. It flags terminal count with a one-cycle pulse and reports run/hold/done status. It sits next to the up counter in the timing/counter library and is used as a one-shot or periodic (auto-reload) interval timer.

---
 rtl/down_counter_timer_if.sv | 41 ++++
 rtl/down_counter_timer.sv | 164 ++++++++++++++++
 tb/tb_down_counter_timer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/down_counter_timer_if.sv
// ---------------------------------------------------------------------------
// down_counter_timer_if
//
// Purpose: groups the control and status signals of down_counter_timer.
//
// Signal summary (directions seen from the timer, i.e. the slave modport):
//   load      in   load load_val into the count and reload registers
//   load_val  in   WIDTH-bit value captured on load
//   start     in   begin or resume counting
//   pause     in   freeze counting while running
//   q         out  current count (registered)
//   tc        out  terminal-count pulse, one cycle wide (registered)
//   busy      out  timer is in RUN or HOLD
//   done      out  timer is in DONE
//
// Handshake semantics: there is no valid/ready pairing. Every control input is
// a level sampled on each rising clock edge. The timer accepts it on that edge
// and produces no back-pressure. Outputs change only after a clock edge.
// ---------------------------------------------------------------------------
interface down_counter_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, start, pause,
        input  q, tc, busy, done
    );

    modport slave (
        input  load, load_val, start, pause,
        output q, tc, busy, done
    );
endinterface

// File: rtl/down_counter_timer.sv
// ---------------------------------------------------------------------------
// down_counter_timer
//
// Purpose: programmable down-counting interval timer with a prescaler.
//   - load captures a start value.
//   - start counts it down to zero at one decrement per PRESCALE cycles.
//   - tc pulses for one cycle on terminal count.
//   - busy and done report the run and finished status.
//
// Parameters:
//   WIDTH     counter width, 2..16
//   PRESCALE  clock cycles per decrement, 1..256
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   bus          --   down_counter_timer_if.slave (load/load_val/start/pause in;
//                     q/tc/busy/done out)
//   dbg_state_o  out  current FSM state (IDLE=0, RUN=1, HOLD=2, DONE=3)
//
// Optional feature macro: DOWN_COUNTER_TIMER_AUTORELOAD_EN
//   Defined:   a terminal tick reloads the last loaded value and keeps running,
//              unless that value is 0.
//   Undefined: one-shot only, and there is no reload register.
// ---------------------------------------------------------------------------
module down_counter_timer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    down_counter_timer_if.slave  bus,
    output logic [1:0]           dbg_state_o
);

    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              tc_q, tc_d;
    logic              count_en;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0]  reload_q, reload_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            q_q      <= '0;
            pcnt_q   <= '0;
            tc_q     <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            pcnt_q   <= pcnt_d;
            tc_q     <= tc_d;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        pcnt_d   = pcnt_q;
        tc_d     = 1'b0;      // tc is a pulse, so it drops unless set below
        count_en = 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
        reload_d = reload_q;
`endif

        if (bus.load) begin
            // load wins over start and pause in every state
            q_d     = bus.load_val;
            pcnt_d  = '0;
            state_d = ST_IDLE;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
            reload_d = bus.load_val;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (q_q != '0) begin
                            state_d = ST_RUN;
                            pcnt_d  = '0;
                        end else begin
                            // nothing to count, so finish immediately
                            state_d = ST_DONE;
                            tc_d    = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // start outranks pause. A start in RUN only keeps counting
                    // and does not restart the prescaler.
                    if (bus.pause && !bus.start) begin
                        state_d = ST_HOLD;
                    end else begin
                        count_en = 1'b1;
                    end
                end
                ST_HOLD: begin
                    // The resume edge counts. Each cycle spent in HOLD then
                    // delays terminal count by exactly one cycle.
                    if (bus.start) begin
                        state_d  = ST_RUN;
                        count_en = 1'b1;
                    end
                end
                ST_DONE: begin
                    // only load or rst leaves DONE
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (count_en) begin
            if (pcnt_q == PCNT_LAST) begin
                pcnt_d = '0;
                // RUN is entered only with q != 0, so q == 1 is the terminal tick
                if (q_q <= WIDTH'(1)) begin
                    tc_d = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
                    if (reload_q != '0) begin
                        q_d     = reload_q;
                        state_d = ST_RUN;
                    end else begin
                        q_d     = '0;
                        state_d = ST_DONE;
                    end
`else
                    q_d     = '0;
                    state_d = ST_DONE;
`endif
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end else begin
                pcnt_d = pcnt_q + PCNT_W'(1);
            end
        end
    end

    assign bus.q       = q_q;
    assign bus.tc      = tc_q;
    assign bus.busy    = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign bus.done    = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

    localparam int W = 4;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    // FSM state codes
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HOLD = 2;
    localparam int S_DONE = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    down_counter_timer_if #(.WIDTH(W)) if1 ();
    down_counter_timer_if #(.WIDTH(W)) if3 ();
    logic [1:0] st1, st3;

    down_counter_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .dbg_state_o(st1)
    );
    down_counter_timer #(.WIDTH(W), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst), .bus(if3), .dbg_state_o(st3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance one edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic ld, input logic [W-1:0] v, input logic st, input logic pa);
        if1.load = ld; if1.load_val = v; if1.start = st; if1.pause = pa;
    endtask

    task automatic drive3(input logic ld, input logic [W-1:0] v, input logic st, input logic pa);
        if3.load = ld; if3.load_val = v; if3.start = st; if3.pause = pa;
    endtask

    initial begin
        logic [W-1:0] ar_seq [6];
        ar_seq[0] = 2; ar_seq[1] = 1; ar_seq[2] = 3;
        ar_seq[3] = 2; ar_seq[4] = 1; ar_seq[5] = 3;

        // ---- reset with load/start asserted ----
        rst = 1'b1;
        drive1(1'b1, 4'd7, 1'b1, 1'b0);
        drive3(1'b1, 4'd7, 1'b1, 1'b0);
        tick(); tick();
        chk("rst_q",     if1.q, 0);
        chk("rst_tc",    if1.tc, 0);
        chk("rst_busy",  if1.busy, 0);
        chk("rst_done",  if1.done, 0);
        chk("rst_state", st1, S_IDLE);
        chk("rst_q3",    if3.q, 0);
        rst = 1'b0;
        drive1(1'b0, 4'd0, 1'b0, 1'b0);
        drive3(1'b0, 4'd0, 1'b0, 1'b0);
        tick();

        // ---- one-shot, PRESCALE=1, load 5 ----
        drive1(1'b1, 4'd5, 1'b0, 1'b0);
        tick();
        drive1(1'b0, 4'd0, 1'b0, 1'b0);
        chk("os_load_q", if1.q, 5);
        chk("os_load_state", st1, S_IDLE);
        drive1(1'b0, 4'd0, 1'b1, 1'b0);
        tick();                                   // edge N
        drive1(1'b0, 4'd0, 1'b0, 1'b0);
        chk("os_start_state", st1, S_RUN);
        chk("os_start_busy", if1.busy, 1);
        chk("os_start_q", if1.q, 5);
        for (int k = 4; k >= 1; k--) begin
            tick();
            chk("os_q", if1.q, k);
            chk("os_tc_low", if1.tc, 0);
        end
        tick();                                   // edge N+5
        chk("os_term_q", if1.q, AR ? 5 : 0);
        chk("os_term_tc", if1.tc, 1);
        chk("os_term_done", if1.done, AR ? 0 : 1);
        chk("os_term_busy", if1.busy, AR ? 1 : 0);
        tick();
        chk("os_tc_fall", if1.tc, 0);
        chk("os_after_done", if1.done, AR ? 0 : 1);

        // ---- zero load and ignored inputs in DONE ----
        drive1(1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        chk("z_load_state", st1, S_IDLE);
        chk("z_load_done", if1.done, 0);
        drive1(1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        drive1(1'b0, 4'd0, 1'b0, 1'b0);
        chk("z_state", st1, S_DONE);
        chk("z_tc", if1.tc, 1);
        chk("z_q", if1.q, 0);
        tick();
        chk("z_tc_fall", if1.tc, 0);
        drive1(1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        drive1(1'b0, 4'd0, 1'b0, 1'b0);
        chk("z_ign_tc", if1.tc, 0);
        chk("z_ign_state", st1, S_DONE);
        chk("z_ign_done", if1.done, 1);

        // ---- abort in RUN at q=3 with load+start+pause ----
        drive1(1'b1, 4'd6, 1'b0, 1'b0);
        tick();
        drive1(1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        drive1(1'b0, 4'd0, 1'b0, 1'b0);
        tick(); tick(); tick();
        chk("ab_pre_q", if1.q, 3);
        chk("ab_pre_state", st1, S_RUN);
        drive1(1'b1, 4'd9, 1'b1, 1'b1);
        tick();
        drive1(1'b0, 4'd0, 1'b0, 1'b0);
        chk("ab_q", if1.q, 9);
        chk("ab_state", st1, S_IDLE);
        chk("ab_busy", if1.busy, 0);
        chk("ab_tc", if1.tc, 0);
        tick();
        chk("ab_hold_q", if1.q, 9);

        // ---- PRESCALE=3, load 2, pause 4 cycles after first tick ----
        drive3(1'b1, 4'd2, 1'b0, 1'b0);
        tick();
        drive3(1'b0, 4'd0, 1'b1, 1'b0);
        tick();                                   // edge N
        drive3(1'b0, 4'd0, 1'b0, 1'b0);
        chk("ps_start_state", st3, S_RUN);
        tick(); chk("ps_q_n1", if3.q, 2);
        tick(); chk("ps_q_n2", if3.q, 2);
        tick(); chk("ps_q_n3", if3.q, 1);
        drive3(1'b0, 4'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin         // edges N+4..N+7
            tick();
            chk("ps_hold_state", st3, S_HOLD);
            chk("ps_hold_q", if3.q, 1);
            chk("ps_hold_busy", if3.busy, 1);
        end
        drive3(1'b0, 4'd0, 1'b1, 1'b0);
        tick();                                   // edge N+8
        drive3(1'b0, 4'd0, 1'b0, 1'b0);
        chk("ps_resume_state", st3, S_RUN);
        chk("ps_resume_q", if3.q, 1);
        tick();                                   // edge N+9
        chk("ps_q_n9", if3.q, 1);
        chk("ps_tc_n9", if3.tc, 0);
        tick();                                   // edge N+10
        chk("ps_term_q", if3.q, AR ? 2 : 0);
        chk("ps_term_tc", if3.tc, 1);
        chk("ps_term_done", if3.done, AR ? 0 : 1);
        tick();
        chk("ps_tc_fall", if3.tc, 0);

`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
        // ---- auto-reload, PRESCALE=1, load 3 ----
        drive1(1'b1, 4'd3, 1'b0, 1'b0);
        tick();
        drive1(1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        drive1(1'b0, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("ar_q", if1.q, ar_seq[k]);
            chk("ar_tc", if1.tc, (ar_seq[k] == 3) ? 1 : 0);
            chk("ar_busy", if1.busy, 1);
            chk("ar_done", if1.done, 0);
        end
`endif

        // ---- reset from an active state ----
        drive1(1'b1, 4'd4, 1'b0, 1'b0);
        tick();
        drive1(1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        drive1(1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_q", if1.q, 0);
        chk("rst2_state", st1, S_IDLE);
        chk("rst2_busy", if1.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
